// File: rtl/mybus_pkg.sv
// Shared Mybus definitions: arbiter FSM states, tag layout constants and tag decode helper.
package mybus_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ADDR,
        ARB_WDATA
    } arb_state_t;

    // reqtag layout: {rw, type[3:0], low[7:0]}; rw=1 marks a read
    localparam int unsigned TAG_RW_BIT = 12;

    localparam logic [TAG_RW_BIT:0] READ_MEM_TAG  = 13'b1_0001_0000_0000;
    localparam logic [TAG_RW_BIT:0] WRITE_MEM_TAG = 13'b0_0001_0000_0000;

    function automatic logic is_read(input logic [TAG_RW_BIT:0] tag);
        return tag[TAG_RW_BIT];
    endfunction

endpackage

// File: rtl/mybus_owner_fifo.sv
// In-order FIFO of client indices owning outstanding read bursts; head is the current response owner.
module mybus_owner_fifo
    import mybus_pkg::*;
#(
    parameter int unsigned W     = 2,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] head_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         do_push;
    logic         do_pop;

    always_comb begin
        empty_o  = (wr_ptr_q == rd_ptr_q);
        full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop   = pop_i && !empty_o;
        // a pop frees the head slot in the same cycle, so push-while-full is allowed alongside it
        do_push  = push_i && (!full_o || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        head_o = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/mybus_rr_arbiter.sv
// Round-robin arbiter of N Bottom-side Mybus masters onto one Top-side Mybus,
// routing read-response bursts back to their issuers in request order.
module mybus_rr_arbiter
    import mybus_pkg::*;
#(
    parameter int unsigned N_CLIENTS       = 4,
    parameter int unsigned DATA_W          = 64,
    parameter int unsigned TAG_W           = 13,
    parameter int unsigned BEATS           = 8,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_CLIENTS-1:0]        cl_reqcyc,
    input  logic [N_CLIENTS*DATA_W-1:0] cl_req,
    input  logic [N_CLIENTS*TAG_W-1:0]  cl_reqtag,
    output logic [N_CLIENTS-1:0]        cl_reqack,
    output logic [N_CLIENTS-1:0]        cl_respcyc,
    output logic [DATA_W-1:0]           cl_resp,
    input  logic [N_CLIENTS-1:0]        cl_respack,
    output logic                        up_bid,
    output logic                        up_reqcyc,
    output logic [DATA_W-1:0]           up_req,
    output logic [TAG_W-1:0]            up_reqtag,
    input  logic                        up_reqack,
    input  logic                        up_respcyc,
    input  logic [DATA_W-1:0]           up_resp,
    output logic                        up_respack,
    output logic                        err_unexp
);

    localparam int unsigned CW = $clog2(N_CLIENTS);
    localparam int unsigned BW = (BEATS > 1) ? $clog2(BEATS) : 1;

    arb_state_t      state_q, state_d;
    logic [CW-1:0]   grant_q, grant_d;
    logic [CW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]   wcnt_q, wcnt_d;
    logic [BW-1:0]   rcnt_q, rcnt_d;
    logic            err_q, err_d;

    logic [N_CLIENTS-1:0] eligible;
    logic                 found;
    logic [CW-1:0]        pick;
    int unsigned          idx;
    logic [CW-1:0]        next_ptr;
    logic [DATA_W-1:0]    sel_req;
    logic [TAG_W-1:0]     sel_tag;
    logic                 sel_rd;
    logic                 fwd_active;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CW-1:0]        fifo_head;
    logic                 resp_beat;

    mybus_owner_fifo #(
        .W     (CW),
        .DEPTH (MAX_OUTSTANDING)
    ) u_owner_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (fifo_push),
        .push_data_i (grant_q),
        .pop_i       (fifo_pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_o      (fifo_head)
    );

    always_comb begin
        sel_req  = cl_req[grant_q*DATA_W +: DATA_W];
        sel_tag  = cl_reqtag[grant_q*TAG_W +: TAG_W];
        sel_rd   = is_read(sel_tag);
        next_ptr = (grant_q == CW'(N_CLIENTS - 1)) ? '0 : grant_q + CW'(1);
    end

    // Reads are held off while every owner slot is taken; writes never need one.
    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < N_CLIENTS; i++) begin
            eligible[i] = cl_reqcyc[i] &&
                          !(is_read(cl_reqtag[i*TAG_W +: TAG_W]) && fifo_full);
        end
    end

    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int unsigned k = 0; k < N_CLIENTS; k++) begin
            idx = (int'(rr_ptr_q) + k) % N_CLIENTS;
            if (!found && eligible[idx]) begin
                found = 1'b1;
                pick  = CW'(idx);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        wcnt_d     = wcnt_q;
        fifo_push  = 1'b0;
        fwd_active = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (found) begin
                    grant_d = pick;
                    state_d = ARB_ADDR;
                end
            end
            ARB_ADDR: begin
                fwd_active = 1'b1;
                if (up_reqack) begin
                    if (sel_rd) begin
                        fifo_push = 1'b1;
                        rr_ptr_d  = next_ptr;
                        state_d   = ARB_IDLE;
                    end else begin
                        wcnt_d  = '0;
                        state_d = ARB_WDATA;
                    end
                end
            end
            ARB_WDATA: begin
                fwd_active = 1'b1;
                if (up_reqack) begin
                    wcnt_d = wcnt_q + BW'(1);
                    if (wcnt_q == BW'(BEATS - 1)) begin
                        wcnt_d   = '0;
                        rr_ptr_d = next_ptr;
                        state_d  = ARB_IDLE;
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_comb begin
        resp_beat = up_respcyc && !fifo_empty && cl_respack[fifo_head];
        fifo_pop  = resp_beat && (rcnt_q == BW'(BEATS - 1));
        rcnt_d    = rcnt_q;
        if (resp_beat) begin
            rcnt_d = fifo_pop ? '0 : rcnt_q + BW'(1);
        end
        err_d = err_q || (up_respcyc && fifo_empty);
    end

    // Every output is forced low while reset is held so no ack escapes in the reset cycle.
    always_comb begin
        up_bid     = reset && (fwd_active || (|cl_reqcyc));
        up_reqcyc  = reset && fwd_active;
        up_req     = (reset && fwd_active) ? sel_req : '0;
        up_reqtag  = (reset && fwd_active) ? sel_tag : '0;
        cl_reqack  = (reset && fwd_active && up_reqack) ?
                     (N_CLIENTS'(1) << grant_q) : '0;
        cl_respcyc = (reset && up_respcyc && !fifo_empty) ?
                     (N_CLIENTS'(1) << fifo_head) : '0;
        cl_resp    = reset ? up_resp : '0;
        // with no owner the beat is swallowed here so the Top side cannot stall
        up_respack = reset && (fifo_empty ? up_respcyc : cl_respack[fifo_head]);
        err_unexp  = err_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ARB_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            wcnt_q   <= '0;
            rcnt_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            wcnt_q   <= wcnt_d;
            rcnt_q   <= rcnt_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_mybus_rr_arbiter.sv
// Directed self-checking bench for mybus_rr_arbiter; the bench plays both the clients and the Top side.
module tb_mybus_rr_arbiter;
    import mybus_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 64;
    localparam int unsigned TW = 13;
    localparam int unsigned NB = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    cl_reqcyc;
    logic [N*DW-1:0] cl_req;
    logic [N*TW-1:0] cl_reqtag;
    logic [N-1:0]    cl_reqack;
    logic [N-1:0]    cl_respcyc;
    logic [DW-1:0]   cl_resp;
    logic [N-1:0]    cl_respack;
    logic            up_bid;
    logic            up_reqcyc;
    logic [DW-1:0]   up_req;
    logic [TW-1:0]   up_reqtag;
    logic            up_reqack;
    logic            up_respcyc;
    logic [DW-1:0]   up_resp;
    logic            up_respack;
    logic            err_unexp;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mybus_rr_arbiter #(
        .N_CLIENTS       (N),
        .DATA_W          (DW),
        .TAG_W           (TW),
        .BEATS           (NB),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cl_reqcyc  (cl_reqcyc),
        .cl_req     (cl_req),
        .cl_reqtag  (cl_reqtag),
        .cl_reqack  (cl_reqack),
        .cl_respcyc (cl_respcyc),
        .cl_resp    (cl_resp),
        .cl_respack (cl_respack),
        .up_bid     (up_bid),
        .up_reqcyc  (up_reqcyc),
        .up_req     (up_req),
        .up_reqtag  (up_reqtag),
        .up_reqack  (up_reqack),
        .up_respcyc (up_respcyc),
        .up_resp    (up_resp),
        .up_respack (up_respack),
        .err_unexp  (err_unexp)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_client(input int c, input logic cyc, input logic [63:0] d,
                                input logic [12:0] t);
        cl_reqcyc[c]        = cyc;
        cl_req[c*DW +: DW]  = d;
        cl_reqtag[c*TW +: TW] = t;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (up_reqcyc !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        if (up_reqcyc !== 1'b1) check(tag, up_reqcyc, 1);
    endtask

    task automatic serve_read(input int c, input logic [63:0] addr);
        wait_req("rd_wait");
        up_reqack = 1'b1;
        #1;
        check("rd_gnt", cl_reqack, 64'(1) << c);
        check("rd_addr", up_req, addr);
        check("rd_tag", up_reqtag, READ_MEM_TAG);
        tick();
        up_reqack = 1'b0;
        drive_client(c, 1'b0, '0, '0);
    endtask

    task automatic serve_write(input int c, input logic [63:0] base);
        wait_req("wr_wait");
        for (int b = 0; b <= NB; b++) begin
            cl_req[c*DW +: DW] = base + 64'(b);
            up_reqack = 1'b1;
            #1;
            check("wr_gnt", cl_reqack, 64'(1) << c);
            check("wr_beat", up_req, base + 64'(b));
            tick();
        end
        up_reqack = 1'b0;
    endtask

    task automatic serve_resp(input int owner, input logic [63:0] base);
        for (int b = 0; b < NB; b++) begin
            up_respcyc = 1'b1;
            up_resp    = base + 64'(b);
            if (b == 0) begin
                cl_respack = ~(4'(1) << owner);
                #1;
                check("resp_foreign_ack", up_respack, 0);
            end
            cl_respack = 4'(1) << owner;
            #1;
            check("resp_route", cl_respcyc, 64'(1) << owner);
            check("resp_data", cl_resp, base + 64'(b));
            check("resp_ack", up_respack, 1);
            tick();
        end
        up_respcyc = 1'b0;
        cl_respack = '0;
    endtask

    // Probe emptiness without crossing a clock edge, so err_unexp is not disturbed.
    task automatic check_empty(input string tag);
        up_respcyc = 1'b1;
        #1;
        check(tag, cl_respcyc, 0);
        check("empty_drop_ack", up_respack, 1);
        up_respcyc = 1'b0;
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset      = 1'b0;
        cl_reqcyc  = '0;
        cl_req     = '0;
        cl_reqtag  = '0;
        cl_respack = '0;
        up_reqack  = 1'b0;
        up_respcyc = 1'b0;
        up_resp    = '0;
        tick();
        tick();

        check("rst_bid", up_bid, 0);
        check("rst_reqcyc", up_reqcyc, 0);
        check("rst_reqack", cl_reqack, 0);
        check("rst_respcyc", cl_respcyc, 0);
        check("rst_err", err_unexp, 0);
        cl_reqcyc  = '1;
        up_respcyc = 1'b1;
        #1;
        check("rst_bid_gated", up_bid, 0);
        check("rst_respack_gated", up_respack, 0);
        cl_reqcyc  = '0;
        up_respcyc = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        // single read from client 2
        drive_client(2, 1'b1, 64'h1000, READ_MEM_TAG);
        #1;
        check("t1_bid", up_bid, 1);
        check("t1_latency", up_reqcyc, 0);
        tick();
        check("t1_reqcyc", up_reqcyc, 1);
        serve_read(2, 64'h1000);
        serve_resp(2, 64'h2000);
        check_empty("t1_empty");

        // write burst from client 1, then next search must start at client 2
        drive_client(1, 1'b1, 64'hA000, WRITE_MEM_TAG);
        serve_write(1, 64'hA000);
        drive_client(1, 1'b0, '0, '0);
        #1;
        check("t2_idle", up_reqcyc, 0);
        drive_client(1, 1'b1, 64'hB100, WRITE_MEM_TAG);
        drive_client(3, 1'b1, 64'hB300, WRITE_MEM_TAG);
        serve_write(3, 64'hB300);
        drive_client(1, 1'b0, '0, '0);
        drive_client(3, 1'b0, '0, '0);
        tick();

        // all four clients requesting: strict rotation 0,1,2,3,0
        for (int c = 0; c < 4; c++) drive_client(c, 1'b1, 64'hC000 + 64'(c) * 64'h100, WRITE_MEM_TAG);
        for (int g = 0; g < 5; g++) begin
            serve_write(g % 4, 64'hC000 + 64'(g % 4) * 64'h100);
            drive_client(g % 4, 1'b1, 64'hC000 + 64'(g % 4) * 64'h100, WRITE_MEM_TAG);
        end
        for (int c = 0; c < 4; c++) drive_client(c, 1'b0, '0, '0);
        tick();

        // fill the owner FIFO, then a 5th read must wait behind a write
        for (int i = 0; i < 4; i++) begin
            drive_client((i + 1) % 4, 1'b1, 64'h4000 + 64'((i + 1) % 4), READ_MEM_TAG);
            serve_read((i + 1) % 4, 64'h4000 + 64'((i + 1) % 4));
        end
        drive_client(1, 1'b1, 64'h4555, READ_MEM_TAG);
        drive_client(2, 1'b1, 64'hE000, WRITE_MEM_TAG);
        serve_write(2, 64'hE000);
        drive_client(2, 1'b0, '0, '0);
        tick();
        tick();
        tick();
        check("t4_stall", up_reqcyc, 0);
        check("t4_bid", up_bid, 1);
        serve_resp(1, 64'h5100);
        serve_read(1, 64'h4555);
        serve_resp(2, 64'h5200);
        serve_resp(3, 64'h5300);
        serve_resp(0, 64'h5000);
        serve_resp(1, 64'h5110);
        check_empty("t4_empty");

        // unexpected response with nothing outstanding
        up_respcyc = 1'b1;
        up_resp    = 64'hDEAD;
        #1;
        check("t5_ack", up_respack, 1);
        check("t5_respcyc", cl_respcyc, 0);
        check("t5_err_pre", err_unexp, 0);
        tick();
        up_respcyc = 1'b0;
        check("t5_err", err_unexp, 1);
        tick();
        tick();
        check("t5_sticky", err_unexp, 1);

        // reset in the middle of a write burst (wcnt==3)
        drive_client(0, 1'b1, 64'hF000, WRITE_MEM_TAG);
        wait_req("t6_wait");
        for (int b = 0; b < 4; b++) begin
            cl_req[0 +: DW] = 64'hF000 + 64'(b);
            up_reqack = 1'b1;
            tick();
        end
        up_respcyc = 1'b1;
        #1;
        check("t6_in_burst", up_reqcyc, 1);
        reset = 1'b0;
        #1;
        check("t6_reqcyc", up_reqcyc, 0);
        check("t6_reqack", cl_reqack, 0);
        check("t6_bid", up_bid, 0);
        check("t6_req", up_req, 0);
        check("t6_respack", up_respack, 0);
        check("t6_err", err_unexp, 0);
        tick();
        reset      = 1'b1;
        up_reqack  = 1'b0;
        up_respcyc = 1'b0;
        drive_client(0, 1'b0, '0, '0);
        #1;
        check("t6_after_idle", up_reqcyc, 0);
        check_empty("t6_fifo_flushed");
        drive_client(3, 1'b1, 64'h7000, READ_MEM_TAG);
        serve_read(3, 64'h7000);
        serve_resp(3, 64'h7100);
        check_empty("t6_empty");
        check("t6_err_clear", err_unexp, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
